// File: rtl/axil_pkg.sv
// Shared AXI4-Lite definitions: bridge state encoding and response codes,
// reused by the interconnect, the master bridge and the DSP register slaves.
package axil_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WR_AW_W,
    WR_B,
    RD_AR,
    RD_R,
    DONE
  } axil_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return resp != RESP_OKAY;
  endfunction

endpackage

// File: rtl/bridge_timeout_ctr.sv
// Per-phase watchdog: counts cycles while enabled and pulses expired on the
// TIMEOUT_CYCLES-th cycle since the last clear. TIMEOUT_CYCLES=0 disables it.
module bridge_timeout_ctr #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic reset_ni,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i) begin
      count_d = count_q + CW'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign expired_o = (TIMEOUT_CYCLES != 0) && enable_i && (count_q == LAST);

endmodule

// File: rtl/axil_master_bridge.sv
// Turns a hold-until-ack CPU register request into one AXI4-Lite master
// transaction and returns a single-cycle ack with read data and error flag.
module axil_master_bridge
  import axil_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int REQ_ADDR_WIDTH = 32,
  parameter int AXI_ADDR_WIDTH = 5,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                      clk_i,
  input  logic                      reset_ni,
  input  logic [REQ_ADDR_WIDTH-1:0] req_addr_i,
  input  logic [DATA_WIDTH-1:0]     req_wdata_i,
  input  logic                      req_we_i,
  input  logic                      req_re_i,
  output logic [DATA_WIDTH-1:0]     req_rdata_o,
  output logic                      req_ack_o,
  output logic                      req_err_o,
  output logic                      busy_o,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_awaddr_o,
  output logic                      m_axi_awvalid_o,
  input  logic                      m_axi_awready_i,
  output logic [DATA_WIDTH-1:0]     m_axi_wdata_o,
  output logic [DATA_WIDTH/8-1:0]   m_axi_wstrb_o,
  output logic                      m_axi_wvalid_o,
  input  logic                      m_axi_wready_i,
  input  logic [1:0]                m_axi_bresp_i,
  input  logic                      m_axi_bvalid_i,
  output logic                      m_axi_bready_o,
  output logic [AXI_ADDR_WIDTH-1:0] m_axi_araddr_o,
  output logic                      m_axi_arvalid_o,
  input  logic                      m_axi_arready_i,
  input  logic [DATA_WIDTH-1:0]     m_axi_rdata_i,
  input  logic [1:0]                m_axi_rresp_i,
  input  logic                      m_axi_rvalid_i,
  output logic                      m_axi_rready_o
);

  localparam int STRB_W = DATA_WIDTH / 8;

  axil_state_e state_q, state_d;

  logic [AXI_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]     rdata_q, rdata_d;
  logic [STRB_W-1:0]         wstrb_q, wstrb_d;
  logic awvalid_q, awvalid_d, wvalid_q, wvalid_d, bready_q, bready_d;
  logic arvalid_q, arvalid_d, rready_q, rready_d;
  logic ack_q, ack_d, err_q, err_d, busy_q, busy_d;

  logic aw_ok, w_ok, expired, in_axi_phase;
  logic unused_addr_hi;

  assign unused_addr_hi = ^req_addr_i[REQ_ADDR_WIDTH-1:AXI_ADDR_WIDTH];

  // A channel counts as finished once its handshake happened earlier or is happening now.
  assign aw_ok = !awvalid_q || m_axi_awready_i;
  assign w_ok  = !wvalid_q  || m_axi_wready_i;
  assign in_axi_phase = (state_q == WR_AW_W) || (state_q == WR_B) ||
                        (state_q == RD_AR)   || (state_q == RD_R);

  bridge_timeout_ctr #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i    (clk_i),
    .reset_ni (reset_ni),
    .clear_i  (state_d != state_q),
    .enable_i (in_axi_phase),
    .expired_o(expired)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      wstrb_q   <= '0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      rready_q  <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      wstrb_q   <= wstrb_d;
      awvalid_q <= awvalid_d;
      wvalid_q  <= wvalid_d;
      bready_q  <= bready_d;
      arvalid_q <= arvalid_d;
      rready_q  <= rready_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  // A handshake landing on the expiring cycle wins, so the slave never sees a dropped transfer.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_we_i)      state_d = WR_AW_W;
        else if (req_re_i) state_d = RD_AR;
      end
      WR_AW_W: begin
        if (aw_ok && w_ok) state_d = WR_B;
        else if (expired)  state_d = DONE;
      end
      WR_B:    if (m_axi_bvalid_i || expired)  state_d = DONE;
      RD_AR: begin
        if (m_axi_arready_i) state_d = RD_R;
        else if (expired)    state_d = DONE;
      end
      RD_R:    if (m_axi_rvalid_i || expired)  state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are computed from the upcoming state so every port comes straight from a flop.
  always_comb begin
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    awvalid_d = 1'b0;
    wvalid_d  = 1'b0;
    bready_d  = 1'b0;
    arvalid_d = 1'b0;
    rready_d  = 1'b0;
    if (state_q == IDLE && (req_we_i || req_re_i)) begin
      addr_d  = req_addr_i[AXI_ADDR_WIDTH-1:0];
      wdata_d = req_wdata_i;
    end
    case (state_d)
      WR_AW_W: begin
        awvalid_d = (state_q == IDLE) || (awvalid_q && !m_axi_awready_i);
        wvalid_d  = (state_q == IDLE) || (wvalid_q && !m_axi_wready_i);
      end
      WR_B:  bready_d  = 1'b1;
      RD_AR: arvalid_d = 1'b1;
      RD_R:  rready_d  = 1'b1;
      DONE: begin
        if (state_q == RD_R && m_axi_rvalid_i) begin
          rdata_d = m_axi_rdata_i;
          err_d   = resp_is_err(m_axi_rresp_i);
        end else if (state_q == WR_B && m_axi_bvalid_i) begin
          rdata_d = '0;
          err_d   = resp_is_err(m_axi_bresp_i);
        end else begin
          rdata_d = '0;
          err_d   = 1'b1;
        end
      end
      default: begin
        rdata_d = '0;
        err_d   = 1'b0;
      end
    endcase
    wstrb_d = {STRB_W{wvalid_d}};
    ack_d   = (state_d == DONE);
    busy_d  = (state_d != IDLE);
  end

  assign req_rdata_o     = rdata_q;
  assign req_ack_o       = ack_q;
  assign req_err_o       = err_q;
  assign busy_o          = busy_q;
  assign m_axi_awaddr_o  = addr_q;
  assign m_axi_awvalid_o = awvalid_q;
  assign m_axi_wdata_o   = wdata_q;
  assign m_axi_wstrb_o   = wstrb_q;
  assign m_axi_wvalid_o  = wvalid_q;
  assign m_axi_bready_o  = bready_q;
  assign m_axi_araddr_o  = addr_q;
  assign m_axi_arvalid_o = arvalid_q;
  assign m_axi_rready_o  = rready_q;

endmodule

// File: tb/tb_axil_master_bridge.sv
// Self-checking bench for axil_master_bridge: delay-configurable AXI-Lite slave,
// vector table, timeout/reset sequences and randomized transactions.
module tb_axil_master_bridge;

  logic        clk_i = 1'b0;
  logic        reset_ni = 1'b1;
  logic [31:0] req_addr_i = '0;
  logic [31:0] req_wdata_i = '0;
  logic        req_we_i = 1'b0;
  logic        req_re_i = 1'b0;
  logic [31:0] req_rdata_o;
  logic        req_ack_o, req_err_o, busy_o;
  logic [4:0]  m_axi_awaddr_o, m_axi_araddr_o;
  logic        m_axi_awvalid_o, m_axi_wvalid_o, m_axi_bready_o, m_axi_arvalid_o, m_axi_rready_o;
  logic [31:0] m_axi_wdata_o;
  logic [3:0]  m_axi_wstrb_o;
  logic        m_axi_awready_i = 1'b0, m_axi_wready_i = 1'b0, m_axi_arready_i = 1'b0;
  logic        m_axi_bvalid_i = 1'b0, m_axi_rvalid_i = 1'b0;
  logic [1:0]  m_axi_bresp_i = '0, m_axi_rresp_i = '0;
  logic [31:0] m_axi_rdata_i = '0;

  typedef struct {
    logic        we;
    logic        re;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          awD;
    int          wD;
    int          bD;
    int          arD;
    int          rD;
    logic [1:0]  bresp;
    logic [1:0]  rresp;
    logic [31:0] sRdata;
    logic        expErr;
    logic [31:0] expRdata;
    int          expLat;
  } vector_t;

  int checks = 0;
  int errors = 0;
  int cfgAwD = 0, cfgWD = 0, cfgBD = 0, cfgArD = 0, cfgRD = 0;
  logic [1:0]  cfgBresp = '0, cfgRresp = '0;
  logic [31:0] cfgRdata = '0;
  bit cfgNeverAr = 1'b0;
  bit allowDrop = 1'b0;
  int hsAw = 0, hsW = 0, hsB = 0, hsAr = 0, hsR = 0;
  logic [4:0]  capAwAddr = '0, capArAddr = '0;
  logic [31:0] capWdata = '0;
  logic [3:0]  capWstrb = '0;
  vector_t vecs[8];

  always #5 clk_i = ~clk_i;

  axil_master_bridge #(
    .DATA_WIDTH(32), .REQ_ADDR_WIDTH(32), .AXI_ADDR_WIDTH(5), .TIMEOUT_CYCLES(8)
  ) dut (
    .clk_i(clk_i), .reset_ni(reset_ni),
    .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
    .req_we_i(req_we_i), .req_re_i(req_re_i),
    .req_rdata_o(req_rdata_o), .req_ack_o(req_ack_o), .req_err_o(req_err_o), .busy_o(busy_o),
    .m_axi_awaddr_o(m_axi_awaddr_o), .m_axi_awvalid_o(m_axi_awvalid_o), .m_axi_awready_i(m_axi_awready_i),
    .m_axi_wdata_o(m_axi_wdata_o), .m_axi_wstrb_o(m_axi_wstrb_o),
    .m_axi_wvalid_o(m_axi_wvalid_o), .m_axi_wready_i(m_axi_wready_i),
    .m_axi_bresp_i(m_axi_bresp_i), .m_axi_bvalid_i(m_axi_bvalid_i), .m_axi_bready_o(m_axi_bready_o),
    .m_axi_araddr_o(m_axi_araddr_o), .m_axi_arvalid_o(m_axi_arvalid_o), .m_axi_arready_i(m_axi_arready_i),
    .m_axi_rdata_i(m_axi_rdata_i), .m_axi_rresp_i(m_axi_rresp_i),
    .m_axi_rvalid_i(m_axi_rvalid_i), .m_axi_rready_o(m_axi_rready_o)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference outcome from the protocol rules: phase delays add, AW/W overlap.
  function automatic vector_t expectFor(input vector_t v);
    vector_t r = v;
    if (v.we) begin
      r.expErr   = (v.bresp != 2'b00);
      r.expRdata = '0;
      r.expLat   = 3 + ((v.awD > v.wD) ? v.awD : v.wD) + v.bD;
    end else begin
      r.expErr   = (v.rresp != 2'b00);
      r.expRdata = v.sRdata;
      r.expLat   = 3 + v.arD + v.rD;
    end
    return r;
  endfunction

  // Slave: each READY/VALID response appears after the configured number of waiting cycles.
  always @(negedge clk_i) begin
    static int awCnt = 0, wCnt = 0, bCnt = 0, arCnt = 0, rCnt = 0;
    if (!reset_ni) begin
      m_axi_awready_i = 0; m_axi_wready_i = 0; m_axi_arready_i = 0;
      m_axi_bvalid_i = 0; m_axi_rvalid_i = 0;
      awCnt = 0; wCnt = 0; bCnt = 0; arCnt = 0; rCnt = 0;
    end else begin
      if (m_axi_awready_i) begin m_axi_awready_i = 0; awCnt = 0; end
      else if (m_axi_awvalid_o) begin if (awCnt >= cfgAwD) m_axi_awready_i = 1; else awCnt++; end
      else awCnt = 0;
      if (m_axi_wready_i) begin m_axi_wready_i = 0; wCnt = 0; end
      else if (m_axi_wvalid_o) begin if (wCnt >= cfgWD) m_axi_wready_i = 1; else wCnt++; end
      else wCnt = 0;
      if (m_axi_arready_i) begin m_axi_arready_i = 0; arCnt = 0; end
      else if (m_axi_arvalid_o) begin if (arCnt >= cfgArD && !cfgNeverAr) m_axi_arready_i = 1; else arCnt++; end
      else arCnt = 0;
      if (m_axi_bvalid_i) begin m_axi_bvalid_i = 0; bCnt = 0; end
      else if (m_axi_bready_o) begin
        if (bCnt >= cfgBD) begin m_axi_bvalid_i = 1; m_axi_bresp_i = cfgBresp; end else bCnt++;
      end else bCnt = 0;
      if (m_axi_rvalid_i) begin m_axi_rvalid_i = 0; rCnt = 0; end
      else if (m_axi_rready_o) begin
        if (rCnt >= cfgRD) begin
          m_axi_rvalid_i = 1; m_axi_rresp_i = cfgRresp; m_axi_rdata_i = cfgRdata;
        end else rCnt++;
      end else rCnt = 0;
    end
  end

  // Monitor sampled just before each rising edge: counts handshakes and checks VALID stability.
  always begin
    static logic pAwV = 0, pAwR = 0, pWV = 0, pWR = 0, pArV = 0, pArR = 0;
    @(negedge clk_i); #3;
    if (reset_ni) begin
      if (pAwV && !pAwR && !allowDrop) checkOutput("awvalid_stable", 32'(m_axi_awvalid_o), 1);
      if (pAwV && pAwR) checkOutput("awvalid_drop", 32'(m_axi_awvalid_o), 0);
      if (pWV && !pWR && !allowDrop) checkOutput("wvalid_stable", 32'(m_axi_wvalid_o), 1);
      if (pWV && pWR) checkOutput("wvalid_drop", 32'(m_axi_wvalid_o), 0);
      if (pArV && !pArR && !allowDrop) checkOutput("arvalid_stable", 32'(m_axi_arvalid_o), 1);
      if (pArV && pArR) checkOutput("arvalid_drop", 32'(m_axi_arvalid_o), 0);
      if (m_axi_awvalid_o && m_axi_awready_i) begin hsAw++; capAwAddr = m_axi_awaddr_o; end
      if (m_axi_wvalid_o && m_axi_wready_i) begin
        hsW++; capWdata = m_axi_wdata_o; capWstrb = m_axi_wstrb_o;
      end
      if (m_axi_arvalid_o && m_axi_arready_i) begin hsAr++; capArAddr = m_axi_araddr_o; end
      if (m_axi_bvalid_i && m_axi_bready_o) hsB++;
      if (m_axi_rvalid_i && m_axi_rready_o) hsR++;
    end
    pAwV = m_axi_awvalid_o; pAwR = m_axi_awready_i;
    pWV = m_axi_wvalid_o;   pWR = m_axi_wready_i;
    pArV = m_axi_arvalid_o; pArR = m_axi_arready_i;
  end

  task automatic waitIdle();
    for (int i = 0; i < 50 && busy_o; i++) begin
      @(posedge clk_i); #1;
    end
    if (busy_o) checkOutput("wait_idle", 32'(busy_o), 0);
  endtask

  task automatic applyStimulus(input vector_t v);
    int cyc;
    bit got;
    logic [31:0] gotRdata;
    logic gotErr;
    waitIdle();
    cfgAwD = v.awD; cfgWD = v.wD; cfgBD = v.bD; cfgArD = v.arD; cfgRD = v.rD;
    cfgBresp = v.bresp; cfgRresp = v.rresp; cfgRdata = v.sRdata;
    @(negedge clk_i);
    hsAw = 0; hsW = 0; hsB = 0; hsAr = 0; hsR = 0;
    req_addr_i = v.addr; req_wdata_i = v.wdata; req_we_i = v.we; req_re_i = v.re;
    cyc = 0; got = 0; gotRdata = '0; gotErr = 0;
    while (!got && cyc < 40) begin
      @(posedge clk_i); #1;
      cyc++;
      if (cyc == 1) begin req_addr_i = $urandom; req_wdata_i = $urandom; end
      if (req_ack_o) begin got = 1; gotRdata = req_rdata_o; gotErr = req_err_o; end
    end
    req_we_i = 0; req_re_i = 0;
    checkOutput("ack_seen", 32'(got), 1);
    checkOutput("latency", cyc, v.expLat);
    checkOutput("rdata", gotRdata, v.expRdata);
    checkOutput("err", 32'(gotErr), 32'(v.expErr));
    @(posedge clk_i); #1;
    checkOutput("ack_single", 32'(req_ack_o), 0);
    if (v.we) begin
      checkOutput("awaddr", 32'(capAwAddr), 32'(v.addr[4:0]));
      checkOutput("wdata", capWdata, v.wdata);
      checkOutput("wstrb", 32'(capWstrb), 32'hF);
      checkOutput("aw_hs", hsAw, 1);
      checkOutput("w_hs", hsW, 1);
      checkOutput("b_hs", hsB, 1);
      checkOutput("ar_hs_wr", hsAr, 0);
    end else begin
      checkOutput("araddr", 32'(capArAddr), 32'(v.addr[4:0]));
      checkOutput("ar_hs", hsAr, 1);
      checkOutput("r_hs", hsR, 1);
      checkOutput("aw_hs_rd", hsAw, 0);
    end
  endtask

  initial begin
    #20000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vector_t v;
    int cyc, arHigh, n;
    bit got;
    logic [31:0] gotRdata;
    logic gotErr;

    #1 reset_ni = 1'b0;
    #2;
    checkOutput("rst_awvalid", 32'(m_axi_awvalid_o), 0);
    checkOutput("rst_wvalid", 32'(m_axi_wvalid_o), 0);
    checkOutput("rst_bready", 32'(m_axi_bready_o), 0);
    checkOutput("rst_arvalid", 32'(m_axi_arvalid_o), 0);
    checkOutput("rst_rready", 32'(m_axi_rready_o), 0);
    checkOutput("rst_ack", 32'(req_ack_o), 0);
    checkOutput("rst_err", 32'(req_err_o), 0);
    checkOutput("rst_busy", 32'(busy_o), 0);
    checkOutput("rst_rdata", req_rdata_o, 0);
    checkOutput("rst_wstrb", 32'(m_axi_wstrb_o), 0);
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;

    //         we re addr           wdata          aw w  b  ar r  bresp  rresp  sRdata         err rdata          lat
    vecs[0] = '{1, 0, 32'h8000_0004, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0,         0, 32'h0,         3};
    vecs[1] = '{0, 1, 32'h0000_0010, 32'h0,         0, 0, 0, 2, 3, 2'b00, 2'b00, 32'h1234_5678, 0, 32'h1234_5678, 8};
    vecs[2] = '{1, 0, 32'h0000_0008, 32'hDEAD_BEEF, 4, 0, 0, 0, 0, 2'b00, 2'b00, 32'h0,         0, 32'h0,         7};
    vecs[3] = '{1, 0, 32'h0000_000C, 32'h1111_2222, 0, 0, 1, 0, 0, 2'b10, 2'b00, 32'h0,         1, 32'h0,         4};
    vecs[4] = '{0, 1, 32'h0000_0014, 32'h0,         0, 0, 0, 0, 0, 2'b00, 2'b00, 32'hA5A5_5A5A, 0, 32'hA5A5_5A5A, 3};
    vecs[5] = '{0, 1, 32'h0000_001C, 32'h0,         0, 0, 0, 1, 1, 2'b00, 2'b11, 32'h0BAD_F00D, 1, 32'h0BAD_F00D, 5};
    vecs[6] = '{1, 1, 32'h0000_0018, 32'h55AA_55AA, 1, 3, 2, 0, 0, 2'b00, 2'b00, 32'h0,         0, 32'h0,         8};
    vecs[7] = '{0, 1, 32'hFFFF_FFE0, 32'h0,         0, 0, 0, 0, 2, 2'b00, 2'b10, 32'h8765_4321, 1, 32'h8765_4321, 5};
    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // AR never accepted: ARVALID must drop after 8 cycles and the read completes with an error.
    waitIdle();
    cfgNeverAr = 1; allowDrop = 1;
    @(negedge clk_i);
    hsAr = 0; hsR = 0;
    req_re_i = 1; req_addr_i = 32'h4;
    cyc = 0; got = 0; arHigh = 0; gotRdata = '1; gotErr = 0;
    while (!got && cyc < 30) begin
      @(posedge clk_i); #1;
      cyc++;
      if (m_axi_arvalid_o) arHigh++;
      if (req_ack_o) begin got = 1; gotRdata = req_rdata_o; gotErr = req_err_o; end
    end
    req_re_i = 0;
    checkOutput("to_ack_seen", 32'(got), 1);
    checkOutput("to_latency", cyc, 9);
    checkOutput("to_arvalid_cycles", arHigh, 8);
    checkOutput("to_err", 32'(gotErr), 1);
    checkOutput("to_rdata", gotRdata, 0);
    checkOutput("to_ar_hs", hsAr, 0);
    waitIdle();
    cfgNeverAr = 0; allowDrop = 0;
    applyStimulus(vecs[4]);

    // Asynchronous reset while waiting for the write response.
    waitIdle();
    cfgAwD = 0; cfgWD = 0; cfgBD = 6; cfgBresp = 2'b00;
    @(negedge clk_i);
    req_we_i = 1; req_addr_i = 32'h8; req_wdata_i = 32'h1357_9BDF;
    n = 0;
    while (!m_axi_bready_o && n < 10) begin @(posedge clk_i); #1; n++; end
    checkOutput("mid_bready_reached", 32'(m_axi_bready_o), 1);
    #2 reset_ni = 1'b0;
    #1;
    checkOutput("mid_rst_bready", 32'(m_axi_bready_o), 0);
    checkOutput("mid_rst_ack", 32'(req_ack_o), 0);
    checkOutput("mid_rst_busy", 32'(busy_o), 0);
    req_we_i = 0;
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;
    @(posedge clk_i); #1;
    checkOutput("post_rst_busy", 32'(busy_o), 0);
    checkOutput("post_rst_bready", 32'(m_axi_bready_o), 0);
    applyStimulus(vecs[1]);

    for (int i = 0; i < 40; i++) begin
      int r;
      v.we = 1'($urandom_range(0, 1));
      v.re = v.we ? 1'($urandom_range(0, 1)) : 1'b1;
      v.addr = $urandom; v.wdata = $urandom; v.sRdata = $urandom;
      v.awD = $urandom_range(0, 3); v.wD = $urandom_range(0, 3); v.bD = $urandom_range(0, 3);
      v.arD = $urandom_range(0, 3); v.rD = $urandom_range(0, 3);
      r = $urandom_range(0, 3);
      v.bresp = (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
      r = $urandom_range(0, 3);
      v.rresp = (r == 1) ? 2'b10 : (r == 2) ? 2'b11 : 2'b00;
      v = expectFor(v);
      applyStimulus(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
